// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Accepts symbolic instruction requests (R-format, LD, SD, BEQ) over a
//   valid/ready handshake, encodes each one into a 32-bit RV64I word, buffers
//   the words in a small FIFO and streams them into the instruction-memory
//   write port at consecutive word addresses starting at BASE_ADDR.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   start               one-cycle pulse opening a load session (IDLE/DONE only)
//   req_valid/req_ready request handshake
//   req_op              00 R, 01 LD, 10 SD, 11 BEQ
//   req_rd/rs1/rs2      register fields
//   req_funct3/funct7b5 R-format function fields
//   req_imm             LD/SD imm[11:0]; BEQ offset[12:1]
//   req_last            final request of the session
//   imem_we/imem_ready  write strobe / memory accept
//   imem_addr           byte address of the word on imem_wdata
//   imem_wdata          encoded instruction word (FIFO head)
//   done                session complete
//   count               words written this session (saturating)
//   err                 sticky illegal-request flag
//
// Optional feature macro: ENCODER_ILLEGAL_CHECK_EN
//   When defined, R-format requests with an unsupported funct3/funct7b5 are
//   consumed but dropped, and err is raised until the next start or reset.
//   When undefined, all fields are encoded verbatim and err is tied to 0.

module instr_encoder_loader #(
  parameter int unsigned        ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR  = '0,
  parameter int unsigned        FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [2:0]        req_funct3,
  input  logic              req_funct7b5,
  input  logic [11:0]       req_imm,
  input  logic              req_last,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              done,
  output logic [ADDR_W-1:0] count,
  output logic              err
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]    occ_q;
  logic [ADDR_W-1:0] addr_q, cnt_q;

  logic full, empty, active, accept, push, pop, restart, legal;
  logic [31:0] enc_word;

  function automatic logic [31:0] encode(input logic [1:0]  op,
                                         input logic [4:0]  rd,
                                         input logic [4:0]  rs1,
                                         input logic [4:0]  rs2,
                                         input logic [2:0]  f3,
                                         input logic        f7b5,
                                         input logic [11:0] imm);
    logic [31:0] w;
    case (op)
      2'b00:   w = {1'b0, f7b5, 5'b0, rs2, rs1, f3, rd, 7'b0110011};
      2'b01:   w = {imm, rs1, 3'b011, rd, 7'b0000011};
      2'b10:   w = {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
      default: w = {imm[11], imm[9:4], rs2, rs1, 3'b000, imm[3:0], imm[10], 7'b1100011};
    endcase
    return w;
  endfunction

  assign full     = (occ_q == (PTR_W+1)'(FIFO_DEPTH));
  assign empty    = (occ_q == '0);
  assign active   = (state_q == S_LOAD) || (state_q == S_DRAIN);
  // Ready depends on occupancy only, so a full FIFO refuses a push even if
  // the head is being popped in the same cycle.
  assign req_ready = (state_q == S_LOAD) && !full;
  assign accept   = req_valid && req_ready;
  assign push     = accept && legal;
  assign imem_we  = active && !empty;
  assign pop      = imem_we && imem_ready;
  assign restart  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign enc_word = encode(req_op, req_rd, req_rs1, req_rs2, req_funct3,
                           req_funct7b5, req_imm);

`ifdef ENCODER_ILLEGAL_CHECK_EN
  logic err_q;

  // Only add/sub/or/and style R-ops are supported; funct7b5 selects sub.
  assign legal = (req_op != 2'b00) ||
                 (((req_funct3 == 3'b000) || (req_funct3 == 3'b110) ||
                   (req_funct3 == 3'b111)) &&
                  (!req_funct7b5 || (req_funct3 == 3'b000)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (restart) begin
      err_q <= 1'b0;
    end else if (accept && !legal) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign legal = 1'b1;
  assign err   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  if (accept && req_last) state_d = S_DRAIN;
      S_DRAIN: if (empty) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      addr_q   <= BASE_ADDR;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ_q <= occ_q + (PTR_W+1)'(1);
        2'b01:   occ_q <= occ_q - (PTR_W+1)'(1);
        default: occ_q <= occ_q;
      endcase
      if (restart) begin
        addr_q <= BASE_ADDR;
        cnt_q  <= '0;
      end else if (pop) begin
        addr_q <= addr_q + ADDR_W'(4);
        if (cnt_q != '1) cnt_q <= cnt_q + ADDR_W'(1);
      end
    end
  end

  // Payload storage carries no reset; validity is tracked by occ_q.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= enc_word;
  end

  assign imem_wdata = imem_we ? mem_q[rd_ptr_q] : 32'h0;
  assign imem_addr  = addr_q;
  assign count      = cnt_q;
  assign done       = (state_q == S_DONE);

endmodule
